// File: rtl/keybuf_entry.sv
// Keypad digit accumulator: nibble edit buffer with backspace/clear/overflow and a valid/ready commit.
// Latency: every output is registered and changes one cycle after its strobe; full is decoded from count.
// Backpressure: after a commit the block waits in HOLD until commit_ready is high. Edits in HOLD are rejected.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   key_in/key_val                new digit strobe and value
//   backspace, clear, enter       edit strobes (priority clear > enter > backspace > key_in)
//   commit_ready                  consumer accepts commit_data
//   out, count, full, overflow    live edit buffer and its status
//   key_reject                    one-cycle pulse when an edit strobe is ignored
//   commit_data, commit_valid     committed value and its valid flag
module keybuf_entry #(
    parameter  int DIGITS   = 8,
    parameter  int DEC_MODE = 0,
    parameter  int OVF_MODE = 0,
    localparam int CNT_W    = $clog2(DIGITS + 1),
    localparam int W        = 4 * DIGITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_in,
    input  logic [3:0]       key_val,
    input  logic             backspace,
    input  logic             clear,
    input  logic             enter,
    input  logic             commit_ready,
    output logic [W-1:0]     out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow,
    output logic             key_reject,
    output logic [W-1:0]     commit_data,
    output logic             commit_valid
);

    typedef enum logic {
        EDIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

    state_t           state_q, state_d;
    logic [W-1:0]     out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             key_reject_q, key_reject_d;
    logic [W-1:0]     commit_data_q, commit_data_d;
    logic             commit_valid_q, commit_valid_d;

    logic             is_full;
    logic             is_empty;
    logic             digit_bad;
    logic [W-1:0]     shifted_in;

    assign is_full    = (count_q == FULL_CNT);
    assign is_empty   = (count_q == '0);
    // In decimal-only mode the hex digits A..F are not legal keystrokes.
    assign digit_bad  = (DEC_MODE != 0) && (key_val > 4'd9);
    // New digit enters at the least-significant nibble; the top nibble falls off.
    assign shifted_in = {out_q[W-5:0], key_val};

    // State register (together with all datapath flops)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= EDIT;
            out_q          <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            key_reject_q   <= 1'b0;
            commit_data_q  <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_q          <= out_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            key_reject_q   <= key_reject_d;
            commit_data_q  <= commit_data_d;
            commit_valid_q <= commit_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EDIT: begin
                // clear outranks enter, so a simultaneous clear cancels the commit
                if (!clear && enter && !is_empty) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (commit_ready) begin
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        out_d          = out_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        key_reject_d   = 1'b0;
        commit_data_d  = commit_data_q;
        commit_valid_d = commit_valid_q;

        case (state_q)
            EDIT: begin
                if (clear) begin
                    out_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (enter) begin
                    if (is_empty) begin
                        key_reject_d = 1'b1;
                    end else begin
                        commit_data_d  = out_q;
                        commit_valid_d = 1'b1;
                        out_d          = '0;
                        count_d        = '0;
                        overflow_d     = 1'b0;
                    end
                end else if (backspace) begin
                    if (is_empty) begin
                        key_reject_d = 1'b1;
                    end else begin
                        out_d   = {4'h0, out_q[W-1:4]};
                        count_d = count_q - CNT_W'(1);
                    end
                end else if (key_in) begin
                    if (digit_bad) begin
                        key_reject_d = 1'b1;
                    end else if (!is_full) begin
                        out_d   = shifted_in;
                        count_d = count_q + CNT_W'(1);
                    end else if (OVF_MODE == 0) begin
                        // Full buffer scrolls: oldest digit is lost, count stays at DIGITS
                        out_d      = shifted_in;
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d   = 1'b1;
                        key_reject_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Edits stay blocked through the handshake cycle itself.
                if (commit_ready) begin
                    commit_valid_d = 1'b0;
                end
                if (clear) begin
                    out_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (enter || backspace || key_in) begin
                    key_reject_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign out          = out_q;
    assign count        = count_q;
    assign full         = is_full;
    assign overflow     = overflow_q;
    assign key_reject   = key_reject_q;
    assign commit_data  = commit_data_q;
    assign commit_valid = commit_valid_q;

endmodule

// File: tb/tb_keybuf_entry.sv
module tb_keybuf_entry;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_in = 1'b0;
    logic [3:0]  key_val = 4'h0;
    logic        backspace = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic        commit_ready = 1'b0;

    // Instance 0: hex, shift on full. Instance 1: decimal, reject on full.
    logic [15:0] o0_out, o0_cdata, o1_out, o1_cdata;
    logic [2:0]  o0_count, o1_count;
    logic        o0_full, o0_ovf, o0_rej, o0_cvld;
    logic        o1_full, o1_ovf, o1_rej, o1_cvld;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    keybuf_entry #(.DIGITS(4), .DEC_MODE(0), .OVF_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .key_in(key_in), .key_val(key_val),
        .backspace(backspace), .clear(clear), .enter(enter), .commit_ready(commit_ready),
        .out(o0_out), .count(o0_count), .full(o0_full), .overflow(o0_ovf),
        .key_reject(o0_rej), .commit_data(o0_cdata), .commit_valid(o0_cvld)
    );

    keybuf_entry #(.DIGITS(4), .DEC_MODE(1), .OVF_MODE(1)) dut1 (
        .clock(clock), .reset(reset), .key_in(key_in), .key_val(key_val),
        .backspace(backspace), .clear(clear), .enter(enter), .commit_ready(commit_ready),
        .out(o1_out), .count(o1_count), .full(o1_full), .overflow(o1_ovf),
        .key_reject(o1_rej), .commit_data(o1_cdata), .commit_valid(o1_cvld)
    );

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_strobes();
        key_in = 1'b0; backspace = 1'b0; clear = 1'b0; enter = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        key_in = 1'b1; key_val = v;
        tick();
        release_strobes();
    endtask

    task automatic do_reset();
        release_strobes();
        commit_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o0_out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", o0_out); end
        checks++; if (o0_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o0_count); end
        checks++; if ({o0_full, o0_ovf, o0_rej, o0_cvld} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o0_full, o0_ovf, o0_rej, o0_cvld}); end
        checks++; if (o0_cdata !== 16'h0) begin failures++; $display("FAIL reset_cdata got=%h exp=0000", o0_cdata); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        checks++; if (o0_out !== 16'h1234) begin failures++; $display("FAIL fill_out got=%h exp=1234", o0_out); end
        checks++; if (o0_count !== 3'd4 || o0_full !== 1'b1) begin failures++; $display("FAIL fill_count got=%0d/%b exp=4/1", o0_count, o0_full); end
        checks++; if (o0_ovf !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%b exp=0", o0_ovf); end
        press(4'h5);
        checks++; if (o0_out !== 16'h2345) begin failures++; $display("FAIL shift_out got=%h exp=2345", o0_out); end
        checks++; if (o0_ovf !== 1'b1 || o0_count !== 3'd4 || o0_rej !== 1'b0) begin failures++; $display("FAIL shift_flags got ovf=%b cnt=%0d rej=%b exp 1/4/0", o0_ovf, o0_count, o0_rej); end
        clear = 1'b1; tick(); release_strobes();
        checks++; if (o0_out !== 16'h0 || o0_count !== 3'd0 || o0_ovf !== 1'b0 || o0_full !== 1'b0) begin failures++; $display("FAIL clear got out=%h cnt=%0d ovf=%b full=%b exp 0/0/0/0", o0_out, o0_count, o0_ovf, o0_full); end
    endtask

    task automatic test_backspace();
        do_reset();
        press(4'hA); press(4'hB);
        checks++; if (o0_out !== 16'h00AB) begin failures++; $display("FAIL bs_pre got=%h exp=00ab", o0_out); end
        backspace = 1'b1; tick(); release_strobes();
        checks++; if (o0_out !== 16'h000A || o0_count !== 3'd1) begin failures++; $display("FAIL bs1 got=%h/%0d exp=000a/1", o0_out, o0_count); end
        backspace = 1'b1; tick(); release_strobes();
        checks++; if (o0_out !== 16'h0 || o0_count !== 3'd0 || o0_rej !== 1'b0) begin failures++; $display("FAIL bs2 got=%h/%0d rej=%b exp=0000/0/0", o0_out, o0_count, o0_rej); end
        backspace = 1'b1; tick(); release_strobes();
        checks++; if (o0_rej !== 1'b1 || o0_out !== 16'h0) begin failures++; $display("FAIL bs_empty_rej got rej=%b out=%h exp 1/0000", o0_rej, o0_out); end
        tick();
        checks++; if (o0_rej !== 1'b0) begin failures++; $display("FAIL rej_one_cycle got=%b exp=0", o0_rej); end
        enter = 1'b1; tick(); release_strobes();
        checks++; if (o0_rej !== 1'b1 || o0_cvld !== 1'b0) begin failures++; $display("FAIL enter_empty got rej=%b vld=%b exp 1/0", o0_rej, o0_cvld); end
    endtask

    task automatic test_commit();
        do_reset();
        press(4'h1); press(4'h2);
        enter = 1'b1; tick(); release_strobes();
        checks++; if (o0_cvld !== 1'b1 || o0_cdata !== 16'h0012) begin failures++; $display("FAIL commit got vld=%b data=%h exp 1/0012", o0_cvld, o0_cdata); end
        checks++; if (o0_out !== 16'h0 || o0_count !== 3'd0) begin failures++; $display("FAIL commit_clear got=%h/%0d exp=0000/0", o0_out, o0_count); end
        tick(); tick();
        checks++; if (o0_cvld !== 1'b1 || o0_cdata !== 16'h0012) begin failures++; $display("FAIL hold_stable got vld=%b data=%h exp 1/0012", o0_cvld, o0_cdata); end
        press(4'h7);
        checks++; if (o0_rej !== 1'b1 || o0_out !== 16'h0 || o0_cvld !== 1'b1) begin failures++; $display("FAIL hold_key got rej=%b out=%h vld=%b exp 1/0000/1", o0_rej, o0_out, o0_cvld); end
        // Handshake cycle with a simultaneous key: key is still rejected.
        commit_ready = 1'b1; key_in = 1'b1; key_val = 4'h7;
        tick();
        commit_ready = 1'b0; release_strobes();
        checks++; if (o0_cvld !== 1'b0 || o0_rej !== 1'b1 || o0_out !== 16'h0) begin failures++; $display("FAIL handshake got vld=%b rej=%b out=%h exp 0/1/0000", o0_cvld, o0_rej, o0_out); end
        press(4'h7);
        checks++; if (o0_out !== 16'h0007 || o0_rej !== 1'b0) begin failures++; $display("FAIL post_hold_key got=%h rej=%b exp=0007/0", o0_out, o0_rej); end
    endtask

    task automatic test_dec_reject();
        do_reset();
        press(4'hC);
        checks++; if (o1_rej !== 1'b1 || o1_count !== 3'd0) begin failures++; $display("FAIL dec_reject got rej=%b cnt=%0d exp 1/0", o1_rej, o1_count); end
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        checks++; if (o1_out !== 16'h9876 || o1_full !== 1'b1) begin failures++; $display("FAIL dec_fill got=%h full=%b exp=9876/1", o1_out, o1_full); end
        press(4'h5);
        checks++; if (o1_out !== 16'h9876 || o1_ovf !== 1'b1 || o1_rej !== 1'b1 || o1_count !== 3'd4) begin failures++; $display("FAIL ovf_reject got out=%h ovf=%b rej=%b cnt=%0d exp 9876/1/1/4", o1_out, o1_ovf, o1_rej, o1_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        clear = 1'b1; key_in = 1'b1; key_val = 4'h3; tick(); release_strobes();
        checks++; if (o0_out !== 16'h0 || o0_count !== 3'd0 || o0_rej !== 1'b0) begin failures++; $display("FAIL clr_key got=%h/%0d rej=%b exp=0000/0/0", o0_out, o0_count, o0_rej); end
        press(4'h1); press(4'h2);
        backspace = 1'b1; key_in = 1'b1; key_val = 4'h3; tick(); release_strobes();
        checks++; if (o0_out !== 16'h0001 || o0_count !== 3'd1 || o0_rej !== 1'b0) begin failures++; $display("FAIL bs_key got=%h/%0d rej=%b exp=0001/1/0", o0_out, o0_count, o0_rej); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        press(4'h1); press(4'h2);
        enter = 1'b1; tick(); release_strobes();
        checks++; if (o0_cvld !== 1'b1) begin failures++; $display("FAIL hold_entry got vld=%b exp=1", o0_cvld); end
        reset = 1'b1; key_in = 1'b1; key_val = 4'h9; tick(); reset = 1'b0; release_strobes();
        checks++; if (o0_cvld !== 1'b0 || o0_cdata !== 16'h0 || o0_out !== 16'h0 || o0_count !== 3'd0 || o0_rej !== 1'b0) begin failures++; $display("FAIL reset_hold got vld=%b data=%h out=%h cnt=%0d rej=%b exp 0/0000/0000/0/0", o0_cvld, o0_cdata, o0_out, o0_count, o0_rej); end
        press(4'h4);
        checks++; if (o0_out !== 16'h0004 || o0_rej !== 1'b0) begin failures++; $display("FAIL reset_edit got=%h rej=%b exp=0004/0", o0_out, o0_rej); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_backspace();
        test_commit();
        test_dec_reject();
        test_simultaneous();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
